intrpt_ctrl: RTL and testbench



---
 rtl/intrpt_ctrl.sv | 121 ++++++++++++
 tb/tb_intrpt_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intrpt_ctrl.sv
// Interrupt controller: synchronizes sources, latches edge/level pending bits and
// commits one prioritized request to the CU. Optional macro: INTRPT_SPURIOUS_CNT_EN.
module intrpt_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_edge_mode,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               mie,
  input  logic               int_taken,
  input  logic               mret,
  output logic               intrpt_vld,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               in_service
`ifdef INTRPT_SPURIOUS_CNT_EN
  ,output logic [7:0]        spurious_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_s_d;

  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_req;
  logic [ID_W-1:0]    w_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_s_d <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_s_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign w_set = w_s & ~r_s_d;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_clr[i] = (r_state == ST_REQ) && int_taken && (irq_id == ID_W'(i));
  end

  // A new edge in the same cycle as the clear keeps the bit set.
  assign w_pend_nxt = (irq_edge_mode & (w_set | (irq_pending & ~w_clr)))
                    | (~irq_edge_mode & w_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_pending <= '0;
    else        irq_pending <= w_pend_nxt;
  end

  assign w_elig = irq_pending & irq_mask;
  assign w_req  = mie & (|w_elig);

  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (w_elig[i]) w_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      intrpt_vld <= 1'b0;
      in_service <= 1'b0;
      irq_id     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_state    <= ST_REQ;
          intrpt_vld <= 1'b1;
          irq_id     <= w_id;
        end
        ST_REQ: if (int_taken) begin
          r_state    <= ST_SVC;
          intrpt_vld <= 1'b0;
          in_service <= 1'b1;
        end
        ST_SVC: if (mret) begin
          r_state    <= ST_IDLE;
          in_service <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          intrpt_vld <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTRPT_SPURIOUS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spurious_cnt <= 8'd0;
    else if (int_taken && (r_state != ST_REQ) && (spurious_cnt != 8'hFF))
      spurious_cnt <= spurious_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_intrpt_ctrl.sv
// Scoreboard bench for intrpt_ctrl: a spec-level model pushes expected outputs,
// a monitor pops and compares each cycle and on every request assertion.
module tb_intrpt_ctrl;
  localparam int NS = 4;
  localparam int SS = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] irq_src = '0, irq_edge_mode = '0, irq_mask = '0;
  logic          mie = 1'b0, int_taken = 1'b0, mret = 1'b0;
  logic          intrpt_vld, in_service;
  logic [IW-1:0] irq_id;
  logic [NS-1:0] irq_pending;
`ifdef INTRPT_SPURIOUS_CNT_EN
  logic [7:0]    spurious_cnt;
`endif

  always #5 clk = ~clk;

  intrpt_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .irq_edge_mode(irq_edge_mode),
    .irq_mask(irq_mask), .mie(mie), .int_taken(int_taken), .mret(mret),
    .intrpt_vld(intrpt_vld), .irq_id(irq_id), .irq_pending(irq_pending),
    .in_service(in_service)
`ifdef INTRPT_SPURIOUS_CNT_EN
    , .spurious_cnt(spurious_cnt)
`endif
  );

  typedef struct packed {
    logic          vld;
    logic          svc;
    logic [IW-1:0] id;
    logic [NS-1:0] pend;
  } snap_t;

  snap_t exp_q[$];
  int    id_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: history of raw samples stands in for the synchronizer.
  logic [NS-1:0] m_hist [SS];
  logic [NS-1:0] m_sd, m_pend;
  int            m_mode;   // 0 waiting, 1 requesting, 2 handler running
  int            m_id;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    m_sd = '0; m_pend = '0; m_mode = 0; m_id = 0;
  endtask

  task automatic model_step();
    logic [NS-1:0] s, nxt;
    int elig;
    snap_t e;
    s = m_hist[SS-1];
    for (int i = 0; i < NS; i++) begin
      if (irq_edge_mode[i])
        nxt[i] = (s[i] && !m_sd[i]) ||
                 (m_pend[i] && !(m_mode == 1 && int_taken && m_id == i));
      else
        nxt[i] = s[i];
    end
    elig = int'(m_pend & irq_mask);
    if (m_mode == 0) begin
      if (mie && elig != 0) begin
        m_mode = 1;
        m_id   = $clog2(elig & -elig);
        id_q.push_back(m_id);
      end
    end else if (m_mode == 1) begin
      if (int_taken) m_mode = 2;
    end else begin
      if (mret) m_mode = 0;
    end
    for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq_src;
    m_sd   = s;
    m_pend = nxt;
    e.vld  = (m_mode == 1);
    e.svc  = (m_mode == 2);
    e.id   = IW'(m_id);
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor
  initial begin
    logic  prev_vld;
    snap_t e, a;
    int    eid;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.vld = intrpt_vld; a.svc = in_service; a.id = irq_id; a.pend = irq_pending;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_state t=%0t act vld=%b svc=%b id=%0d pend=%b exp vld=%b svc=%b id=%0d pend=%b",
                   $time, a.vld, a.svc, a.id, a.pend, e.vld, e.svc, e.id, e.pend);
        end
        if (intrpt_vld && !prev_vld) begin
          n_cmp++;
          if (id_q.size() == 0) begin
            n_err++;
            $display("FAIL request_id t=%0t act id=%0d exp no request", $time, irq_id);
          end else begin
            eid = id_q.pop_front();
            if (int'(irq_id) != eid) begin
              n_err++;
              $display("FAIL request_id t=%0t act id=%0d exp id=%0d", $time, irq_id, eid);
            end
          end
        end
        prev_vld = intrpt_vld;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_taken();
    int_taken = 1'b1; tick(1); int_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; tick(1); mret = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must drop without a clock edge.
  task automatic do_reset(input bit chk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_async_vld", int'(intrpt_vld), 0);
      check("rst_async_svc", int'(in_service), 0);
      check("rst_async_pend", int'(irq_pending), 0);
    end
    exp_q.delete();
    id_q.delete();
    irq_src = '0; irq_edge_mode = '0; irq_mask = '0;
    mie = 1'b0; int_taken = 1'b0; mret = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_vld", int'(intrpt_vld), 0);
    check("reset_id", int'(irq_id), 0);
    check("reset_pend", int'(irq_pending), 0);
    check("reset_svc", int'(in_service), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Latency: source 2, edge mode
    tick(1);
    irq_edge_mode = 4'b1111; irq_mask = 4'b0100; mie = 1'b1; irq_src[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lat_pend_edge3", int'(irq_pending[2]), 1);
    check("lat_vld_edge3", int'(intrpt_vld), 0);
    @(posedge clk); #1;
    check("lat_vld_edge4", int'(intrpt_vld), 1);
    check("lat_id_edge4", int'(irq_id), 2);
    tick(1); pulse_taken(); tick(2); pulse_mret(); tick(3);

    // Simultaneous sources 1 and 3, back-to-back via mret
    do_reset(0);
    tick(1);
    irq_edge_mode = 4'b1111; irq_mask = 4'b1010; mie = 1'b1; irq_src = 4'b1010;
    tick(5); pulse_taken(); tick(2); pulse_mret();
    tick(2);
    check("b2b_vld", int'(intrpt_vld), 1);
    check("b2b_id", int'(irq_id), 3);
    pulse_taken(); tick(1); pulse_mret(); tick(3);

    // Committed request survives mie/mask drop (level source 1)
    do_reset(0);
    tick(1);
    irq_edge_mode = 4'b0000; irq_mask = 4'b0010; mie = 1'b1; irq_src[1] = 1'b1;
    tick(5);
    mie = 1'b0; irq_mask = 4'b0000; irq_src[1] = 1'b0;
    tick(4);
    check("commit_vld", int'(intrpt_vld), 1);
    pulse_taken();
    check("commit_svc", int'(in_service), 1);
    tick(2); pulse_mret(); tick(3);

    // New edge coincides with int_taken on source 0
    do_reset(0);
    tick(1);
    irq_edge_mode = 4'b0001; irq_mask = 4'b0001; mie = 1'b1; irq_src[0] = 1'b1;
    tick(6);
    irq_src[0] = 1'b0;
    tick(4);
    irq_src[0] = 1'b1;
    tick(2);
    pulse_taken();
    check("set_wins_pend", int'(irq_pending[0]), 1);
    tick(2); pulse_mret();
    tick(2);
    check("set_wins_rereq", int'(intrpt_vld), 1);
    check("set_wins_id", int'(irq_id), 0);

    // Async reset while requesting
    do_reset(1);

`ifdef INTRPT_SPURIOUS_CNT_EN
    tick(1);
    repeat (3) begin pulse_taken(); tick(1); end
    check("spur_cnt", int'(spurious_cnt), 3);
    check("spur_idle_vld", int'(intrpt_vld), 0);
    check("spur_idle_svc", int'(in_service), 0);
`endif

    // Randomized phase
    tick(1);
    irq_edge_mode = NS'($urandom); irq_mask = NS'($urandom); mie = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 49) begin
        irq_edge_mode = NS'($urandom);
        irq_mask      = NS'($urandom);
        mie           = ($urandom_range(0, 4) != 0);
      end
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
      int_taken = ($urandom_range(0, 3) == 0);
      mret      = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    int_taken = 1'b0; mret = 1'b0;
    tick(3);
    check("req_queue_drained", id_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
